fetch_controller: RTL and testbench

Sequences the hard-coded instruction memory for the MIPS core. It owns the program counter and drives the word-aligned fetch address. It buffers fetched words in a 2-entry prefetch queue and hands them to decode over a valid/ready handshake. It also handles branch/jump redirects, end-of-program detection and misaligned-target faults.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_controller_if.sv | 42 ++++
 rtl/fetch_queue.sv | 68 ++++++
 rtl/fetch_controller.sv | 91 +++++++++
 tb/tb_fetch_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding, queue entry
// layout and the default program bounds tied to the instruction memory depth.
package fetch_pkg;

    localparam int WORD_BYTES = 4;
    localparam int IMEM_WORDS = 114;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_LAST_ADDR = 32'((IMEM_WORDS - 1) * WORD_BYTES);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch controller bus: instruction memory port, decode handshake, redirect
// request and status flags.
interface fetch_controller_if;

    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstr;
    logic [31:0] OutPC;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        Done;
    logic        Fault;

    modport master (
        output Address,
        input  Instruction,
        output OutValid,
        input  OutReady,
        output OutInstr,
        output OutPC,
        input  Redirect,
        input  RedirectTarget,
        output Done,
        output Fault
    );

    modport slave (
        input  Address,
        output Instruction,
        input  OutValid,
        output OutReady,
        input  OutInstr,
        input  OutPC,
        output Redirect,
        output RedirectTarget,
        input  Done,
        input  Fault
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry in-order prefetch FIFO of {pc, instr}. Flush empties it and wins
// over a same-cycle push; push together with pop on a full queue is legal.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head_data,
    output logic [1:0]   count
);

    fetch_entry_t ent_q [2];
    fetch_entry_t ent_d [2];
    logic         head_q, head_d;
    logic [1:0]   count_q, count_d;
    logic         wr_idx;

    // Slot after the last valid entry; equals the head slot when full, which is
    // exactly the one a same-cycle pop frees.
    assign wr_idx = head_q ^ count_q[0];

    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        head_d   = head_q;
        count_d  = count_q;
        if (flush) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                ent_d[wr_idx] = push_data;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Payload is never observed while its slot is empty, so it carries no reset.
    always_ff @(posedge clk) begin
        ent_q[0] <= ent_d[0];
        ent_q[1] <= ent_d[1];
    end

    assign head_data = (count_q != 2'd0) ? ent_q[head_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fills the prefetch queue, and
// handles redirects, end-of-program and misaligned-target faults.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] LAST_ADDR = DEFAULT_LAST_ADDR
) (
    input  logic                Clk,
    input  logic                Rst_n,
    fetch_controller_if.master  bus
);

    logic [1:0]   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         push, pop, flush;
    logic [1:0]   count;
    logic         out_valid, free_slot, redirect_ok;
    fetch_entry_t head, push_data;

    assign out_valid   = (count != 2'd0) && (state_q != ST_FAULT);
    assign pop         = out_valid && bus.OutReady;
    assign free_slot   = (count != 2'd2) || pop;
    assign redirect_ok = bus.Redirect && (state_q != ST_FAULT);
    assign push_data   = '{pc: pc_q, instr: bus.Instruction};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect_ok) begin
            flush = 1'b1;
            if (!is_aligned(bus.RedirectTarget)) begin
                state_d = ST_FAULT;
            end else begin
                pc_d    = bus.RedirectTarget;
                state_d = (bus.RedirectTarget <= LAST_ADDR) ? ST_FETCH : ST_DONE;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (free_slot) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'(WORD_BYTES);
                        if (pc_q == LAST_ADDR) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((count == 2'd0) || (count == 2'd1 && pop)) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue u_queue (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_data),
        .head_data (head),
        .count     (count)
    );

    assign bus.Address  = pc_q;
    assign bus.OutValid = out_valid;
    assign bus.OutInstr = head.instr;
    assign bus.OutPC    = head.pc;
    assign bus.Done     = (state_q == ST_DONE);
    assign bus.Fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized traffic
// checked against an in-order program-stream reference model.
module tb_fetch_controller;

    localparam logic [31:0] LAST = 32'h0000_01C4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_controller_if bus ();

    logic [31:0] mem [0:255];
    assign bus.Instruction = mem[bus.Address[9:2]];

    fetch_controller #(.RESET_PC(32'h0), .LAST_ADDR(LAST)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: the program is the ordered stream exp_pc, exp_pc+4, ... up to LAST.
    logic [31:0] exp_pc;
    bit          fault_exp;
    bit          prev_valid, prev_rdy, prev_redir;
    logic [31:0] prev_pc, prev_instr;
    int          pops;
    logic [31:0] last_pop_pc;

    task automatic model_reset();
        exp_pc      = 32'h0;
        fault_exp   = 1'b0;
        prev_valid  = 1'b0;
        prev_rdy    = 1'b0;
        prev_redir  = 1'b0;
        prev_pc     = 32'h0;
        prev_instr  = 32'h0;
        pops        = 0;
        last_pop_pc = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.OutReady = 1'b0;
        bus.Redirect = 1'b0;
        bus.RedirectTarget = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a negedge: applies inputs, checks current outputs against the
    // model, advances the model over the coming edge, ends at the next negedge.
    task automatic tick(input bit rdy, input bit rd, input logic [31:0] tgt);
        bit done_exp;
        bus.OutReady = rdy;
        bus.Redirect = rd;
        bus.RedirectTarget = tgt;
        done_exp = !fault_exp && (exp_pc > LAST);
        checks++;
        if (bus.Done !== done_exp) begin
            errors++;
            $display("FAIL done got %b exp %b (exp_pc %h)", bus.Done, done_exp, exp_pc);
        end
        checks++;
        if (bus.Fault !== fault_exp) begin
            errors++;
            $display("FAIL fault got %b exp %b", bus.Fault, fault_exp);
        end
        checks++;
        if (bus.Address[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL addr_align got %h", bus.Address);
        end
        if (fault_exp || prev_redir) begin
            checks++;
            if (bus.OutValid !== 1'b0) begin
                errors++;
                $display("FAIL valid_after_redirect got %b exp 0", bus.OutValid);
            end
        end else if (prev_valid && !prev_rdy) begin
            checks++;
            if (bus.OutValid !== 1'b1 || bus.OutPC !== prev_pc || bus.OutInstr !== prev_instr) begin
                errors++;
                $display("FAIL stall_hold got v%b pc %h ins %h exp pc %h ins %h",
                         bus.OutValid, bus.OutPC, bus.OutInstr, prev_pc, prev_instr);
            end
        end
        if (bus.OutValid === 1'b1 && rdy) begin
            checks++;
            if (bus.OutPC !== exp_pc || bus.OutInstr !== mem[exp_pc[9:2]]) begin
                errors++;
                $display("FAIL pop got pc %h ins %h exp pc %h ins %h",
                         bus.OutPC, bus.OutInstr, exp_pc, mem[exp_pc[9:2]]);
            end
            pops++;
            last_pop_pc = bus.OutPC;
            exp_pc = exp_pc + 32'd4;
        end
        prev_valid = bus.OutValid;
        prev_rdy   = rdy;
        prev_pc    = bus.OutPC;
        prev_instr = bus.OutInstr;
        prev_redir = rd && !fault_exp;
        if (rd && !fault_exp) begin
            if (tgt[1:0] != 2'b00) fault_exp = 1'b1;
            else exp_pc = tgt;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Address !== 32'h0 || bus.OutValid !== 1'b0 || bus.OutInstr !== 32'h0 ||
            bus.OutPC !== 32'h0 || bus.Done !== 1'b0 || bus.Fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got addr %h v%b ins %h pc %h d%b f%b exp all zero",
                     bus.Address, bus.OutValid, bus.OutInstr, bus.OutPC, bus.Done, bus.Fault);
        end
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (bus.OutValid !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_valid got %b exp 0", bus.OutValid);
        end
    endtask

    task automatic test_stream();
        tick(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'(i * 4) || bus.OutInstr !== mem[i]) begin
                errors++;
                $display("FAIL stream[%0d] got v%b pc %h ins %h exp pc %h ins %h",
                         i, bus.OutValid, bus.OutPC, bus.OutInstr, 32'(i * 4), mem[i]);
            end
            tick(1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h0 || bus.Address !== 32'h8) begin
            errors++;
            $display("FAIL bp_hold got v%b pc %h addr %h exp v1 pc 0 addr 8",
                     bus.OutValid, bus.OutPC, bus.Address);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'(i * 4)) begin
                errors++;
                $display("FAIL bp_release[%0d] got v%b pc %h exp pc %h",
                         i, bus.OutValid, bus.OutPC, 32'(i * 4));
            end
            tick(1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.OutPC !== 32'h8 || bus.Address !== 32'h10) begin
            errors++;
            $display("FAIL redir_setup got pc %h addr %h exp pc 8 addr 10", bus.OutPC, bus.Address);
        end
        tick(1'b1, 1'b1, 32'h40);
        checks++;
        if (bus.OutValid !== 1'b0 || bus.Address !== 32'h40) begin
            errors++;
            $display("FAIL redir_n1 got v%b addr %h exp v0 addr 40", bus.OutValid, bus.Address);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h40 || bus.OutInstr !== mem[16]) begin
            errors++;
            $display("FAIL redir_n2 got v%b pc %h ins %h exp pc 40 ins %h",
                     bus.OutValid, bus.OutPC, bus.OutInstr, mem[16]);
        end
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h1C4);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.OutValid === 1'b1) n++;
            tick(1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (n != 1 || bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL redir_last got outputs %0d done %b exp 1 and 1", n, bus.Done);
        end
    endtask

    task automatic test_end_of_program();
        do_reset();
        for (int i = 0; i < 200 && bus.Done !== 1'b1; i++) tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL eop_timeout got done %b exp 1", bus.Done);
        end
        checks++;
        if (pops != 114 || last_pop_pc !== 32'h1C4 || bus.Address !== 32'h1C8) begin
            errors++;
            $display("FAIL eop got pops %0d last %h addr %h exp 114 1c4 1c8",
                     pops, last_pop_pc, bus.Address);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.Address !== 32'h1C8 || bus.OutValid !== 1'b0) begin
            errors++;
            $display("FAIL eop_hold got addr %h v%b exp 1c8 v0", bus.Address, bus.OutValid);
        end
        tick(1'b1, 1'b1, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL eop_restart got v%b pc %h done %b exp v1 pc 0 d0",
                     bus.OutValid, bus.OutPC, bus.Done);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_fault();
        logic [31:0] addr_save;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);
        addr_save = bus.Address;
        tick(1'b1, 1'b1, 32'h42);
        checks++;
        if (bus.Fault !== 1'b1 || bus.OutValid !== 1'b0 || bus.Address !== addr_save) begin
            errors++;
            $display("FAIL fault_entry got f%b v%b addr %h exp f1 v0 addr %h",
                     bus.Fault, bus.OutValid, bus.Address, addr_save);
        end
        tick(1'b1, 1'b1, 32'h40);
        tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.Fault !== 1'b1 || bus.OutValid !== 1'b0 || bus.Address !== addr_save) begin
            errors++;
            $display("FAIL fault_sticky got f%b v%b addr %h exp f1 v0 addr %h",
                     bus.Fault, bus.OutValid, bus.Address, addr_save);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear got %b exp 0", bus.Fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.Address !== 32'h8) begin
            errors++;
            $display("FAIL async_setup got v%b addr %h exp v1 addr 8", bus.OutValid, bus.Address);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.OutValid !== 1'b0 || bus.Address !== 32'h0 || bus.OutPC !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got v%b addr %h pc %h exp all zero",
                     bus.OutValid, bus.Address, bus.OutPC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.OutPC !== 32'h0) begin
            errors++;
            $display("FAIL async_restart got v%b pc %h exp v1 pc 0", bus.OutValid, bus.OutPC);
        end
    endtask

    task automatic test_random();
        int fault_age;
        do_reset();
        fault_age = 0;
        for (int i = 0; i < 2000; i++) begin
            bit          rdy, rd;
            logic [31:0] tgt;
            int          r;
            rdy = ($urandom_range(0, 9) < 7);
            r   = $urandom_range(0, 99);
            rd  = 1'b0;
            tgt = 32'h0;
            if (r < 3) begin
                rd  = 1'b1;
                tgt = 32'($urandom_range(0, 113)) << 2;
            end else if (r == 3) begin
                rd  = 1'b1;
                tgt = 32'($urandom_range(100, 113)) << 2;
            end else if (r == 4) begin
                rd  = 1'b1;
                tgt = 32'h200 + (32'($urandom_range(0, 63)) << 2);
            end else if (r == 5 && $urandom_range(0, 3) == 0) begin
                rd  = 1'b1;
                tgt = (32'($urandom_range(0, 113)) << 2) | 32'($urandom_range(1, 3));
            end
            tick(rdy, rd, tgt);
            if (fault_exp) fault_age++;
            if (fault_age > 4) begin
                do_reset();
                fault_age = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        bus.OutReady = 1'b0;
        bus.Redirect = 1'b0;
        bus.RedirectTarget = 32'h0;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_end_of_program();
        test_fault();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
